// File: rtl/mult_final_adder_8x8_if.sv
// rtl/mult_final_adder_8x8_if.sv - operand/result handshake bundle for the final product adder
interface mult_final_adder_8x8_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      pp0;
    logic [15:0]      pp1;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [15:0]      product;
    logic             zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, pp0, pp1, in_tag, out_ready,
        input  in_ready, out_valid, product, zero, out_tag
    );

    modport slave (
        input  in_valid, pp0, pp1, in_tag, out_ready,
        output in_ready, out_valid, product, zero, out_tag
    );
endinterface

// File: rtl/mult_final_adder_8x8.sv
// rtl/mult_final_adder_8x8.sv - two-stage carry-propagate adder closing the signed 8x8 multiplier
module mult_final_adder_8x8 #(
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mult_final_adder_8x8_if.slave   bus
);
    logic             s1_valid;
    logic [7:0]       s1_lo;
    logic             s1_c8;
    logic [7:0]       s1_hi0;
    logic [7:0]       s1_hi1;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [15:0]      s2_product;
    logic             s2_zero;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_free;
    logic             s1_adv;
    logic             in_acc;
    logic [8:0]       lo_full;
    logic [7:0]       hi_sum;

    assign s2_free = !s2_valid || bus.out_ready;
    assign s1_adv  = s1_valid && s2_free;
    assign bus.in_ready = !s1_valid || s2_free;
    assign in_acc  = bus.in_valid && bus.in_ready;

    assign lo_full = {1'b0, bus.pp0[7:0]} + {1'b0, bus.pp1[7:0]};
    // Bit-16 carry is dropped: the tree already folded in the sign-correction constants.
    assign hi_sum  = s1_hi0 + s1_hi1 + {7'd0, s1_c8};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c8    <= 1'b0;
            s1_hi0   <= '0;
            s1_hi1   <= '0;
            s1_tag   <= '0;
        end else if (in_acc) begin
            s1_valid <= 1'b1;
            s1_lo    <= lo_full[7:0];
            s1_c8    <= lo_full[8];
            s1_hi0   <= bus.pp0[15:8];
            s1_hi1   <= bus.pp1[15:8];
            s1_tag   <= bus.in_tag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_product <= '0;
            s2_zero    <= 1'b0;
            s2_tag     <= '0;
        end else if (s1_adv) begin
            s2_valid   <= 1'b1;
            s2_product <= {hi_sum, s1_lo};
            s2_zero    <= ({hi_sum, s1_lo} == 16'h0000);
            s2_tag     <= s1_tag;
        end else if (bus.out_ready) begin
            s2_valid   <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.product   = s2_product;
    assign bus.zero      = s2_zero;
    assign bus.out_tag   = s2_tag;
endmodule

// File: tb/tb_mult_final_adder_8x8.sv
// tb/tb_mult_final_adder_8x8.sv - scoreboard bench for the pipelined final product adder
module tb_mult_final_adder_8x8;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_final_adder_8x8_if #(.TAG_W(TAG_W)) bus ();
    mult_final_adder_8x8 #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] p;
        logic        z;
        logic [3:0]  t;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("product", {16'd0, bus.product}, {16'd0, e.p});
                chk("zero", {31'd0, bus.zero}, {31'd0, e.z});
                chk("out_tag", {28'd0, bus.out_tag}, {28'd0, e.t});
                if (e.lat) chk("latency", cyc, e.acc + 2);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                        input logic [15:0] p, input logic z, input bit lat);
        int   n;
        exp_t e;
        n = 0;
        bus.in_valid = 1'b1;
        bus.pp0      = a;
        bus.pp1      = b;
        bus.in_tag   = t;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept", {31'd0, bus.in_ready}, 32'd1);
        e.p = p; e.z = z; e.t = t; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] v0 [8];
    logic [15:0] v1 [8];
    logic [15:0] vp [8];
    logic        vz [8];

    initial begin
        v0 = '{16'h0001, 16'h0080, 16'h1234, 16'h8000, 16'h7FFF, 16'h00F0, 16'hABCD, 16'hFF00};
        v1 = '{16'h0002, 16'h0080, 16'h4321, 16'h8000, 16'h0001, 16'h0F10, 16'h5433, 16'h00FF};
        vp = '{16'h0003, 16'h0100, 16'h5555, 16'h0000, 16'h8000, 16'h1000, 16'h0000, 16'hFFFF};
        vz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.pp0       = '0;
        bus.pp1       = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_product", {16'd0, bus.product}, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd0);
        chk("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(16'h00FF, 16'h0001, 4'h0, 16'h0100, 1'b0, 1'b1); idle(); drain();
        send(16'hFFFF, 16'h0001, 4'hA, 16'h0000, 1'b1, 1'b1); idle(); drain();
        send(16'h3000, 16'h1000, 4'h3, 16'h4000, 1'b0, 1'b1); idle(); drain();
        send(16'hFFE0, 16'h000B, 4'h4, 16'hFFEB, 1'b0, 1'b1); idle(); drain();

        for (int i = 0; i < 8; i++)
            send(v0[i], v1[i], i[3:0], vp[i], vz[i], 1'b1);
        idle();
        drain();

        bus.out_ready = 1'b0;
        send(16'h0102, 16'h0304, 4'h1, 16'h0406, 1'b0, 1'b0);
        send(16'h00FF, 16'h00FF, 4'h2, 16'h01FE, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.pp0      = 16'h8001;
        bus.pp1      = 16'h7FFF;
        bus.in_tag   = 4'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_product_stable", {16'd0, bus.product}, 32'h0406);
        end
        chk("bp_accepted", sb.size(), 2);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(16'h8001, 16'h7FFF, 4'h3, 16'h0000, 1'b1, 1'b0);
        idle();
        drain();

        bus.out_ready = 1'b0;
        send(16'h1111, 16'h1111, 4'h1, 16'h2222, 1'b0, 1'b0);
        send(16'h2222, 16'h2222, 4'h2, 16'h4444, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_product", {16'd0, bus.product}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(16'h5000, 16'h0A0B, 4'h5, 16'h5A0B, 1'b0, 1'b1);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
